lfsr_gen: RTL

//  Parametrised Fibonacci LFSR pseudo-random generator; successor of the fixed 8-bit lab LFSR.

---
 rtl/lfsr_gen_pkg.sv | 40 ++++
 rtl/lfsr_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lfsr_gen_pkg.sv
// Shared definitions for the lfsr_gen pseudo-random generator.
// Holds the legal width range, the default seed and a table of
// maximal-length Fibonacci tap masks per width
// (bit i of a mask = tap at stage i+1).
package lfsr_gen_pkg;

  localparam int unsigned LFSR_MIN_WIDTH = 3;
  localparam int unsigned LFSR_MAX_WIDTH = 16;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'h0001;

  // Maximal-length tap masks, widths 3..16; zero for an unsupported width.
  function automatic logic [15:0] lfsr_default_taps(input int unsigned width);
    logic [15:0] taps;
    taps = 16'h0000;
    case (width)
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  function automatic logic lfsr_width_ok(input int unsigned width);
    return (width >= LFSR_MIN_WIDTH) && (width <= LFSR_MAX_WIDTH);
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR pseudo-random generator.
// Shifts left one stage per enabled cycle with the XOR of the tapped
// stages entering bit 0. Supports runtime seed load, all-zero lockup
// recovery to SEED and a one-cycle wrap pulse when the state returns to
// the reference value (the last loaded seed, or SEED after reset).
//
// Optional build macro: LFSR_PERIOD_EN adds a saturating step counter and
// reports the length of the last completed sequence on period; without it
// period is tied to zero.
//
// Ports:
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous reset, active-high
//   en       in   1      advance one step this cycle
//   load     in   1      load seed_in this cycle (wins over en)
//   seed_in  in   WIDTH  runtime seed value
//   prg_out  out  WIDTH  current LFSR state
//   bit_out  out  1      serial output, prg_out[WIDTH-1]
//   lockup   out  1      pulse: an all-zero state was replaced by SEED
//   wrap     out  1      pulse: state returned to the reference value
//   period   out  WIDTH  steps of the last completed sequence
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(lfsr_default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] prg_out,
  output logic             bit_out,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  // Elaboration-time parameter checks.
  if (SEED == '0) begin : g_seed_zero
    $error("lfsr_gen: SEED must be nonzero");
  end
  if (!lfsr_width_ok(WIDTH)) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be within 3..16");
  end

  logic [WIDTH-1:0] prg_q, prg_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q, wrap_d;
  logic             fb_c;
  logic [WIDTH-1:0] step_c;

  // One Fibonacci step of the current state.
  assign fb_c   = ^(prg_q & TAPS);
  assign step_c = {prg_q[WIDTH-2:0], fb_c};

  // Next state: load beats en; a zero state is never kept, SEED replaces it.
  always_comb begin
    prg_d    = prg_q;
    ref_d    = ref_q;
    lockup_d = 1'b0;
    wrap_d   = 1'b0;
    if (load) begin
      if (seed_in == '0) begin
        prg_d    = SEED;
        ref_d    = SEED;
        lockup_d = 1'b1;
      end else begin
        prg_d = seed_in;
        ref_d = seed_in;
      end
    end else if (en) begin
      // Only reachable with taps lacking the top stage; recover like a zero load.
      if (step_c == '0) begin
        prg_d    = SEED;
        lockup_d = 1'b1;
      end else begin
        prg_d = step_c;
      end
      wrap_d = (prg_d == ref_q);
    end
  end

  // State, reference and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prg_q    <= SEED;
      ref_q    <= SEED;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      prg_q    <= prg_d;
      ref_q    <= ref_d;
      lockup_q <= lockup_d;
      wrap_q   <= wrap_d;
    end
  end

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] cnt_inc_c;

  // Saturating step count, including the current step.
  assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);

  // Count steps since the reference; latch the length on wrap.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      if (wrap_d) begin
        period_d = cnt_inc_c;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign period = period_q;
`else
  assign period = '0;
`endif

  assign prg_out = prg_q;
  assign bit_out = prg_q[WIDTH-1];
  assign lockup  = lockup_q;
  assign wrap    = wrap_q;

endmodule
